// File: rtl/axi_ar_rr_arbiter.sv
// ============================================================================
// Module   : axi_ar_rr_arbiter
// Brief    : Round-robin sharing of one AXI4 read master (AR/R) between
//            NUM_REQ requesters, with index-tagged IDs and per-requester
//            outstanding-read limits.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_ar_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = $clog2(NUM_REQ),
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MAX_TXNS       = 8
) (
    input  logic                                aclk,
    input  logic                                rst,
    // requester side
    input  logic [NUM_REQ*AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [NUM_REQ*8-1:0]                s_axi_arlen,
    input  logic [NUM_REQ*3-1:0]                s_axi_arsize,
    input  logic [NUM_REQ*2-1:0]                s_axi_arburst,
    input  logic [NUM_REQ*3-1:0]                s_axi_arprot,
    input  logic [NUM_REQ-1:0]                  s_axi_arvalid,
    output logic [NUM_REQ-1:0]                  s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]           s_axi_rdata,
    output logic [AXI_ID_WIDTH-1:0]             s_axi_rid,
    output logic [1:0]                          s_axi_rresp,
    output logic                                s_axi_rlast,
    output logic [NUM_REQ-1:0]                  s_axi_rvalid,
    input  logic [NUM_REQ-1:0]                  s_axi_rready,
    // master side
    output logic [AXI_ID_WIDTH+IDX_W-1:0]       m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]           m_axi_araddr,
    output logic [7:0]                          m_axi_arlen,
    output logic [2:0]                          m_axi_arsize,
    output logic [1:0]                          m_axi_arburst,
    output logic [2:0]                          m_axi_arprot,
    output logic                                m_axi_arvalid,
    input  logic                                m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]           m_axi_rdata,
    input  logic [AXI_ID_WIDTH+IDX_W-1:0]       m_axi_rid,
    input  logic [1:0]                          m_axi_rresp,
    input  logic                                m_axi_rlast,
    input  logic                                m_axi_rvalid,
    output logic                                m_axi_rready,
    output logic                                route_err
);

    localparam int               c_CNT_W  = $clog2(MAX_TXNS + 1);
    localparam int               c_MID_W  = AXI_ID_WIDTH + IDX_W;
    localparam logic [IDX_W:0]   c_NREQ   = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] c_LAST   = IDX_W'(NUM_REQ - 1);
    localparam logic [0:0]       c_IDLE   = 1'b0;
    localparam logic [0:0]       c_ISSUE  = 1'b1;

    logic [0:0]                r_state;
    logic [IDX_W-1:0]          r_rr_ptr;
    logic                      r_arvalid;
    logic [c_MID_W-1:0]        r_arid;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]                r_arlen;
    logic [2:0]                r_arsize;
    logic [1:0]                r_arburst;
    logic [2:0]                r_arprot;
    logic                      r_route_err;

    logic [NUM_REQ-1:0]        w_elig;
    logic [NUM_REQ-1:0]        w_inc;
    logic [NUM_REQ-1:0]        w_dec;
    logic [NUM_REQ-1:0]        w_cnt_zero;
    logic                      w_grant_vld;
    logic [IDX_W-1:0]          w_grant_idx;
    logic [IDX_W-1:0]          w_pos;
    logic [IDX_W-1:0]          w_next_ptr;
    logic                      w_accept;
    logic [IDX_W-1:0]          w_r_idx;
    logic                      w_r_ok;
    logic                      w_r_last_hs;
    logic                      w_underflow;
    logic                      w_bad_beat;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_pos       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if ((int'(r_rr_ptr) + k) >= NUM_REQ)
                w_pos = IDX_W'(int'(r_rr_ptr) + k - NUM_REQ);
            else
                w_pos = IDX_W'(int'(r_rr_ptr) + k);
            if (w_elig[w_pos]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_pos;
            end
        end
    end

    assign w_accept   = (r_state == c_IDLE) && w_grant_vld;
    assign w_next_ptr = (w_grant_idx == c_LAST) ? '0 : w_grant_idx + IDX_W'(1);

    always_comb begin
        s_axi_arready = '0;
        if (w_accept)
            s_axi_arready[w_grant_idx] = 1'b1;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_rr_ptr  <= '0;
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_arprot  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant_vld) begin
                        r_arid    <= {w_grant_idx,
                                      s_axi_arid[w_grant_idx*AXI_ID_WIDTH +: AXI_ID_WIDTH]};
                        r_araddr  <= s_axi_araddr[w_grant_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                        r_arlen   <= s_axi_arlen[w_grant_idx*8 +: 8];
                        r_arsize  <= s_axi_arsize[w_grant_idx*3 +: 3];
                        r_arburst <= s_axi_arburst[w_grant_idx*2 +: 2];
                        r_arprot  <= s_axi_arprot[w_grant_idx*3 +: 3];
                        r_arvalid <= 1'b1;
                        r_rr_ptr  <= w_next_ptr;
                        r_state   <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign m_axi_arid    = r_arid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = r_arsize;
    assign m_axi_arburst = r_arburst;
    assign m_axi_arprot  = r_arprot;
    assign m_axi_arvalid = r_arvalid;

    // R path: purely combinational steering on the ID index bits.
    assign w_r_idx = m_axi_rid[c_MID_W-1 -: IDX_W];
    assign w_r_ok  = ({1'b0, w_r_idx} < c_NREQ);

    always_comb begin
        s_axi_rvalid = '0;
        m_axi_rready = 1'b1;
        if (w_r_ok) begin
            s_axi_rvalid[w_r_idx] = m_axi_rvalid;
            m_axi_rready          = s_axi_rready[w_r_idx];
        end
    end

    assign s_axi_rdata = m_axi_rdata;
    assign s_axi_rid   = m_axi_rid[AXI_ID_WIDTH-1:0];
    assign s_axi_rresp = m_axi_rresp;
    assign s_axi_rlast = m_axi_rlast;

    assign w_r_last_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast && w_r_ok;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_dec_ok;

        assign w_inc[i]      = w_accept && (w_grant_idx == IDX_W'(i));
        assign w_dec[i]      = w_r_last_hs && (w_r_idx == IDX_W'(i));
        assign w_cnt_zero[i] = (r_cnt == '0);
        assign w_dec_ok      = w_dec[i] && !w_cnt_zero[i];
        assign w_elig[i]     = s_axi_arvalid[i] && (r_cnt < c_CNT_W'(MAX_TXNS));

        always_ff @(posedge aclk or posedge rst) begin
            if (rst)
                r_cnt <= '0;
            else if (w_inc[i] && !w_dec_ok)
                r_cnt <= r_cnt + c_CNT_W'(1);
            else if (!w_inc[i] && w_dec_ok)
                r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign w_underflow = |(w_dec & w_cnt_zero);
    assign w_bad_beat  = m_axi_rvalid && !w_r_ok;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst)
            r_route_err <= 1'b0;
        else if (w_underflow || w_bad_beat)
            r_route_err <= 1'b1;
    end

    assign route_err = r_route_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_ar_rr_arbiter.sv
// ============================================================================
// Module   : tb_axi_ar_rr_arbiter
// Brief    : Directed self-checking bench for axi_ar_rr_arbiter (4- and
//            3-requester instances, MAX_TXNS=2).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_ar_rr_arbiter;

    logic aclk = 1'b0;
    logic rst  = 1'b1;
    always #5 aclk = ~aclk;

    // 4-requester instance
    logic [15:0]  s_arid;
    logic [255:0] s_araddr;
    logic [31:0]  s_arlen;
    logic [11:0]  s_arsize;
    logic [7:0]   s_arburst;
    logic [11:0]  s_arprot;
    logic [3:0]   s_arvalid, s_arready;
    logic [63:0]  s_rdata;
    logic [3:0]   s_rid;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic [3:0]   s_rvalid, s_rready;
    logic [5:0]   m_arid;
    logic [63:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst;
    logic [2:0]   m_arprot;
    logic         m_arvalid, m_arready;
    logic [63:0]  m_rdata;
    logic [5:0]   m_rid;
    logic [1:0]   m_rresp;
    logic         m_rlast, m_rvalid, m_rready, route_err;

    // 3-requester instance
    logic [11:0]  b_s_arid;
    logic [191:0] b_s_araddr;
    logic [23:0]  b_s_arlen;
    logic [8:0]   b_s_arsize;
    logic [5:0]   b_s_arburst;
    logic [8:0]   b_s_arprot;
    logic [2:0]   b_s_arvalid, b_s_arready;
    logic [63:0]  b_s_rdata;
    logic [3:0]   b_s_rid;
    logic [1:0]   b_s_rresp;
    logic         b_s_rlast;
    logic [2:0]   b_s_rvalid, b_s_rready;
    logic [5:0]   b_m_arid;
    logic [63:0]  b_m_araddr;
    logic [7:0]   b_m_arlen;
    logic [2:0]   b_m_arsize;
    logic [1:0]   b_m_arburst;
    logic [2:0]   b_m_arprot;
    logic         b_m_arvalid, b_m_arready;
    logic [63:0]  b_m_rdata;
    logic [5:0]   b_m_rid;
    logic [1:0]   b_m_rresp;
    logic         b_m_rlast, b_m_rvalid, b_m_rready, b_route_err;

    axi_ar_rr_arbiter #(
        .NUM_REQ(4), .AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64), .MAX_TXNS(2)
    ) u_dut (
        .aclk(aclk), .rst(rst),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arprot(s_arprot),
        .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .s_axi_rdata(s_rdata), .s_axi_rid(s_rid), .s_axi_rresp(s_rresp),
        .s_axi_rlast(s_rlast), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arprot(m_arprot),
        .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rid(m_rid), .m_axi_rresp(m_rresp),
        .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
        .route_err(route_err)
    );

    axi_ar_rr_arbiter #(
        .NUM_REQ(3), .AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64), .MAX_TXNS(2)
    ) u_dut3 (
        .aclk(aclk), .rst(rst),
        .s_axi_arid(b_s_arid), .s_axi_araddr(b_s_araddr), .s_axi_arlen(b_s_arlen),
        .s_axi_arsize(b_s_arsize), .s_axi_arburst(b_s_arburst), .s_axi_arprot(b_s_arprot),
        .s_axi_arvalid(b_s_arvalid), .s_axi_arready(b_s_arready),
        .s_axi_rdata(b_s_rdata), .s_axi_rid(b_s_rid), .s_axi_rresp(b_s_rresp),
        .s_axi_rlast(b_s_rlast), .s_axi_rvalid(b_s_rvalid), .s_axi_rready(b_s_rready),
        .m_axi_arid(b_m_arid), .m_axi_araddr(b_m_araddr), .m_axi_arlen(b_m_arlen),
        .m_axi_arsize(b_m_arsize), .m_axi_arburst(b_m_arburst), .m_axi_arprot(b_m_arprot),
        .m_axi_arvalid(b_m_arvalid), .m_axi_arready(b_m_arready),
        .m_axi_rdata(b_m_rdata), .m_axi_rid(b_m_rid), .m_axi_rresp(b_m_rresp),
        .m_axi_rlast(b_m_rlast), .m_axi_rvalid(b_m_rvalid), .m_axi_rready(b_m_rready),
        .route_err(b_route_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] id, input logic [63:0] addr);
        s_arid[i*4 +: 4]    = id;
        s_araddr[i*64 +: 64] = addr;
    endtask

    initial begin
        s_arid = '0; s_araddr = '0; s_arprot = '0; s_arvalid = '0; s_rready = '0;
        s_arlen   = {8'd4, 8'd3, 8'd2, 8'd1};
        s_arsize  = {4{3'd3}};
        s_arburst = {4{2'b01}};
        m_arready = 1'b0; m_rdata = '0; m_rid = '0; m_rresp = '0;
        m_rlast = 1'b0; m_rvalid = 1'b0;
        b_s_arid = '0; b_s_araddr = '0; b_s_arlen = '0; b_s_arsize = '0;
        b_s_arburst = '0; b_s_arprot = '0; b_s_arvalid = '0; b_s_rready = '0;
        b_m_arready = 1'b0; b_m_rdata = '0; b_m_rid = '0; b_m_rresp = '0;
        b_m_rlast = 1'b0; b_m_rvalid = 1'b0;

        // reset state
        tick; tick;
        check("rst_arvalid", m_arvalid, 0);
        check("rst_arready", s_arready, 0);
        check("rst_arid", m_arid, 0);
        check("rst_araddr", m_araddr, 0);
        check("rst_route_err", route_err, 0);
        rst = 1'b0;

        // all requesters active: grants 0,1,2,3,0, one AR every 2 cycles
        for (int i = 0; i < 4; i++) set_req(i, 4'(8 + i), 64'h1000 * (i + 1));
        tick;
        s_arvalid = 4'hF;
        m_arready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            int g;
            g = n % 4;
            check("t1_grant", s_arready, 64'(1 << g));
            check("t1_idle_arvalid", m_arvalid, 0);
            tick;
            check("t1_arvalid", m_arvalid, 1);
            check("t1_arid", m_arid, 64'((g << 4) | (8 + g)));
            check("t1_araddr", m_araddr, 64'h1000 * (g + 1));
            check("t1_issue_noready", s_arready, 0);
            tick;
        end
        s_arvalid = 4'h0;

        // requester 2 alone, downstream ready delayed 3 cycles
        set_req(2, 4'h5, 64'h8000_0000);
        m_arready = 1'b0;
        s_arvalid = 4'b0100;
        #1;
        check("t2_grant", s_arready, 4'b0100);
        tick;
        s_arvalid = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) m_arready = 1'b1;
            #1;
            check("t2_arvalid", m_arvalid, 1);
            check("t2_arid", m_arid, 6'h25);
            check("t2_araddr", m_araddr, 64'h8000_0000);
            check("t2_arlen", m_arlen, 8'd3);
            check("t2_noready", s_arready, 0);
            tick;
        end
        check("t2_drop", m_arvalid, 0);

        // reset while in ISSUE
        set_req(0, 4'h1, 64'h100);
        m_arready = 1'b0;
        s_arvalid = 4'b1001;
        #1;
        check("t6_grant3", s_arready, 4'b1000);
        tick;
        check("t6_issue", m_arvalid, 1);
        check("t6_arid", m_arid, 6'h3B);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_drop", m_arvalid, 0);
        check("t6_arid_clr", m_arid, 0);
        tick;
        rst = 1'b0;
        #1;
        check("t6_grant0", s_arready, 4'b0001);
        s_arvalid = 4'b0000;

        // outstanding limit on requester 1
        set_req(1, 4'h3, 64'h2000);
        m_arready = 1'b1;
        s_arvalid = 4'b0010;
        #1;
        for (int a = 0; a < 2; a++) begin
            check("t3_grant", s_arready, 4'b0010);
            tick;
            check("t3_arvalid", m_arvalid, 1);
            check("t3_arid", m_arid, 6'h13);
            tick;
        end
        check("t3_stall", s_arready, 0);
        tick;
        check("t3_stall2", s_arready, 0);
        check("t3_no_ar", m_arvalid, 0);
        m_rid = 6'h13; m_rvalid = 1'b1; m_rlast = 1'b1;
        m_rdata = 64'hDEAD_BEEF_0123_4567; m_rresp = 2'b10;
        s_rready = 4'b0010;
        #1;
        check("t3_rvalid", s_rvalid, 4'b0010);
        check("t3_rid", s_rid, 4'h3);
        check("t3_rready", m_rready, 1);
        check("t3_rdata", s_rdata, 64'hDEAD_BEEF_0123_4567);
        check("t3_rresp", s_rresp, 2'b10);
        check("t3_rlast", s_rlast, 1);
        check("t3_still_max", s_arready, 0);
        tick;
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        check("t3_reelig", s_arready, 4'b0010);
        tick;
        check("t3_third_ar", m_arvalid, 1);
        check("t3_third_arid", m_arid, 6'h13);
        check("t3_no_err", route_err, 0);
        tick;
        s_arvalid = 4'b0000;

        // R back-pressure and burst on requester 3
        set_req(3, 4'hB, 64'h3000);
        s_arvalid = 4'b1000;
        #1;
        for (int a = 0; a < 2; a++) begin
            check("t4_grant", s_arready, 4'b1000);
            tick;
            check("t4_arid", m_arid, 6'h3B);
            tick;
        end
        check("t4_blocked", s_arready, 0);
        m_rid = 6'h3B; m_rvalid = 1'b1; m_rlast = 1'b0; s_rready = 4'b0000;
        #1;
        check("t4_hold_rready", m_rready, 0);
        check("t4_rvalid", s_rvalid, 4'b1000);
        check("t4_rid", s_rid, 4'hB);
        tick;
        check("t4_hold_rready2", m_rready, 0);
        s_rready = 4'b1000;
        for (int b = 0; b < 4; b++) begin
            m_rlast = (b == 3);
            #1;
            check("t4_beat_rready", m_rready, 1);
            check("t4_still_blocked", s_arready, 0);
            tick;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        check("t4_reelig", s_arready, 4'b1000);
        check("t4_no_err", route_err, 0);
        s_arvalid = 4'b0000;

        // last beat for a requester with nothing outstanding
        m_rid = 6'h00; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 4'b0001;
        #1;
        check("uf_pre", route_err, 0);
        tick;
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        check("uf_err", route_err, 1);

        // NUM_REQ=3: valid routing then out-of-range index
        b_m_rid = 6'h21; b_m_rvalid = 1'b1; b_s_rready = 3'b100;
        #1;
        check("t5_route2", b_s_rvalid, 3'b100);
        check("t5_rid", b_s_rid, 4'h1);
        check("t5_rready", b_m_rready, 1);
        b_s_rready = 3'b000;
        #1;
        check("t5_rready_low", b_m_rready, 0);
        b_m_rid = 6'h30;
        #1;
        check("t5_drop_rready", b_m_rready, 1);
        check("t5_no_rvalid", b_s_rvalid, 0);
        check("t5_err_pre", b_route_err, 0);
        tick;
        b_m_rvalid = 1'b0;
        #1;
        check("t5_err", b_route_err, 1);
        tick;
        check("t5_err_sticky", b_route_err, 1);

        rst = 1'b1;
        tick;
        check("end_err_clr", route_err, 0);
        check("end_err_clr3", b_route_err, 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
